halflife_input_cond: RTL and testbench

- Front-end conditioner that sits directly upstream of the half-life timer core and drives its up, down, load and in[3:0] inputs.
- Turns raw pad signals (bouncy push-buttons, DIP nibble) into clean single-cycle strobes and a captured nibble.
- Per-button path: 2-FF synchronisation, debounce and rising-edge detection; up/down additionally auto-repeat while held.

---
 rtl/halflife_pkg.sv | 22 ++
 rtl/halflife_debounce.sv | 63 ++++++
 rtl/halflife_input_cond.sv | 149 ++++++++++++++
 tb/tb_halflife_input_cond.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/halflife_pkg.sv
// Shared definitions for the half-life timer front end: repeat FSM states,
// default timing constants and the switch nibble width.
package halflife_pkg;

   localparam int NIBBLE_W                = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int DEFAULT_REPEAT_DELAY    = 12500000;
   localparam int DEFAULT_REPEAT_RATE     = 2500000;

   // Auto-repeat state for a held up/down button
   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_WAIT   = 2'd1,
      RPT_REPEAT = 2'd2
   } repeat_state_e;

   // Larger of two integers, used to size the shared repeat timer
   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/halflife_debounce.sv
// One button path: 2-FF synchroniser, stability counter that accepts a new
// level only after DEBOUNCE_CYCLES consecutive mismatching cycles, and a
// registered rising-edge strobe of the accepted level.
module halflife_debounce
   import halflife_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             syncMeta_q;
   logic             syncOut_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             rise_q;

   // The count only advances while the synchronised input disagrees with the
   // accepted level; any agreeing cycle throws the partial count away.
   always_comb begin
      stable_d = stable_q;
      count_d  = '0;
      if (syncOut_q != stable_q) begin
         if (count_q == CNT_LAST) begin
            stable_d = syncOut_q;
            count_d  = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // Synchroniser, debounce state and rise strobe; the strobe is formed from
   // the next accepted level so it lines up with the level change itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncMeta_q <= 1'b0;
         syncOut_q  <= 1'b0;
         stable_q   <= 1'b0;
         count_q    <= '0;
         rise_q     <= 1'b0;
      end else begin
         syncMeta_q <= raw_i;
         syncOut_q  <= syncMeta_q;
         stable_q   <= stable_d;
         count_q    <= count_d;
         rise_q     <= stable_d & ~stable_q;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/halflife_input_cond.sv
// Front-end conditioner for the half-life timer core: debounces the three
// buttons, auto-repeats up/down while held, suppresses both while they are
// pressed together, and captures the switch nibble on each load.
module halflife_input_cond
   import halflife_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                up_raw,
   input  logic                down_raw,
   input  logic                load_raw,
   input  logic [NIBBLE_W-1:0] in_raw,
   output logic                up_pulse,
   output logic                down_pulse,
   output logic                load_pulse,
   output logic [NIBBLE_W-1:0] in_q,
   output logic                in_valid,
   output logic                up_held,
   output logic                down_held
);

   localparam int TIMER_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
   localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);

   // Index 0 is the up button, index 1 the down button, index 2 load
   logic [2:0]          rawBtn;
   logic [2:0]          btnLevel;
   logic [2:0]          btnRise;
   logic                conflict;

   repeat_state_e       state_q [2];
   logic [TIMER_W-1:0]  timer_q [2];
   logic [1:0]          pulse_q;

   logic [NIBBLE_W-1:0] inMeta_q;
   logic [NIBBLE_W-1:0] inSync_q;
   logic [NIBBLE_W-1:0] inCapture_q;
   logic                inValid_q;
   logic                loadPulse_q;

   assign rawBtn = {load_raw, down_raw, up_raw};

   // Identical synchronise/debounce/edge path for every button
   for (genvar b = 0; b < 3; b++) begin : g_btn
      halflife_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (rawBtn[b]),
         .level_o (btnLevel[b]),
         .rise_o  (btnRise[b])
      );
   end

   // Both directions held at once means the user intent is ambiguous
   assign conflict = btnLevel[0] & btnLevel[1];

   // Up/down repeat FSMs: press pulse, one long delay, then a steady rate.
   // A conflict parks both in IDLE so only a fresh press restarts them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= RPT_IDLE;
            timer_q[i] <= '0;
            pulse_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            pulse_q[i] <= 1'b0;
            if (conflict) begin
               state_q[i] <= RPT_IDLE;
               timer_q[i] <= '0;
            end else begin
               case (state_q[i])
                  RPT_IDLE: begin
                     if (btnRise[i]) begin
                        pulse_q[i] <= 1'b1;
                        timer_q[i] <= '0;
                        state_q[i] <= RPT_WAIT;
                     end
                  end
                  RPT_WAIT: begin
                     if (!btnLevel[i]) begin
                        timer_q[i] <= '0;
                        state_q[i] <= RPT_IDLE;
                     end else if (timer_q[i] == DELAY_LAST) begin
                        pulse_q[i] <= 1'b1;
                        timer_q[i] <= '0;
                        state_q[i] <= RPT_REPEAT;
                     end else begin
                        timer_q[i] <= timer_q[i] + 1'b1;
                     end
                  end
                  RPT_REPEAT: begin
                     if (!btnLevel[i]) begin
                        timer_q[i] <= '0;
                        state_q[i] <= RPT_IDLE;
                     end else if (timer_q[i] == RATE_LAST) begin
                        pulse_q[i] <= 1'b1;
                        timer_q[i] <= '0;
                     end else begin
                        timer_q[i] <= timer_q[i] + 1'b1;
                     end
                  end
                  default: begin
                     timer_q[i] <= '0;
                     state_q[i] <= RPT_IDLE;
                  end
               endcase
            end
         end
      end
   end

   // Nibble switches are only synchronised; they are sampled at load time
   // and held until the next load, with a sticky flag once any load happened.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inMeta_q    <= '0;
         inSync_q    <= '0;
         inCapture_q <= '0;
         inValid_q   <= 1'b0;
         loadPulse_q <= 1'b0;
      end else begin
         inMeta_q    <= in_raw;
         inSync_q    <= inMeta_q;
         loadPulse_q <= btnRise[2] & btnLevel[2];
         if (btnRise[2] && btnLevel[2]) begin
            inCapture_q <= inSync_q;
            inValid_q   <= 1'b1;
         end
      end
   end

   assign up_pulse   = pulse_q[0];
   assign down_pulse = pulse_q[1];
   assign load_pulse = loadPulse_q;
   assign in_q       = inCapture_q;
   assign in_valid   = inValid_q;
   assign up_held    = btnLevel[0];
   assign down_held  = btnLevel[1];

endmodule

// File: tb/tb_halflife_input_cond.sv
// Directed bench for halflife_input_cond with short timing parameters.
// Pulse arrival times are logged against a bench cycle counter and compared
// with hand-computed cycle numbers.
module tb_halflife_input_cond;

   logic       clk = 1'b0;
   logic       rst;
   logic       upRaw;
   logic       downRaw;
   logic       loadRaw;
   logic [3:0] inRaw;
   logic       up_pulse;
   logic       down_pulse;
   logic       load_pulse;
   logic [3:0] in_q;
   logic       in_valid;
   logic       up_held;
   logic       down_held;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base;
   int base2;
   int upQ[$];
   int downQ[$];
   int loadQ[$];

   halflife_input_cond #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (16),
      .REPEAT_RATE     (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up_raw     (upRaw),
      .down_raw   (downRaw),
      .load_raw   (loadRaw),
      .in_raw     (inRaw),
      .up_pulse   (up_pulse),
      .down_pulse (down_pulse),
      .load_pulse (load_pulse),
      .in_q       (in_q),
      .in_valid   (in_valid),
      .up_held    (up_held),
      .down_held  (down_held)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Bench cycle counter: value after each rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Log the cycle number of every strobe, sampled just after the edge
   always @(posedge clk) begin
      #1;
      if (up_pulse)   upQ.push_back(cyc);
      if (down_pulse) downQ.push_back(cyc);
      if (load_pulse) loadQ.push_back(cyc);
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Hold input values for a number of clock cycles, ending on a falling edge
   task automatic applyStimulus(input logic u, input logic d, input logic l,
                                input logic [3:0] n, input int cycles);
      upRaw   = u;
      downRaw = d;
      loadRaw = l;
      inRaw   = n;
      repeat (cycles) @(negedge clk);
   endtask

   // Compare a logged pulse list against the expected cycle numbers
   task automatic checkQueue(input string tag, input int got[$], input int exp[$]);
      checkOutput($sformatf("%s_count", tag), got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         checkOutput($sformatf("%s_at%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
      end
   endtask

   task automatic clearQueues();
      upQ.delete();
      downQ.delete();
      loadQ.delete();
   endtask

   initial begin
      rst     = 1'b1;
      upRaw   = 1'b0;
      downRaw = 1'b0;
      loadRaw = 1'b0;
      inRaw   = 4'h0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_up_pulse",   up_pulse,   0);
      checkOutput("rst_down_pulse", down_pulse, 0);
      checkOutput("rst_load_pulse", load_pulse, 0);
      checkOutput("rst_in_q",       in_q,       0);
      checkOutput("rst_in_valid",   in_valid,   0);
      checkOutput("rst_up_held",    up_held,    0);
      checkOutput("rst_down_held",  down_held,  0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 4'h0, 4);

      // Clean press held 10 cycles: one pulse at cycle 6, no repeat
      $display("[TB] clean press");
      clearQueues();
      base = cyc + 1;
      applyStimulus(1, 0, 0, 4'h0, 10);
      checkOutput("press_up_held", up_held, 1);
      applyStimulus(0, 0, 0, 4'h0, 12);
      checkOutput("press_up_released", up_held, 0);
      checkQueue("press_up", upQ, {base + 6});
      checkOutput("press_down_count", downQ.size(), 0);
      checkOutput("press_load_count", loadQ.size(), 0);

      // Bounce 1,0,1,0 then steady high: one pulse 6 cycles after final rise
      $display("[TB] bounce");
      clearQueues();
      applyStimulus(1, 0, 0, 4'h0, 1);
      applyStimulus(0, 0, 0, 4'h0, 1);
      applyStimulus(1, 0, 0, 4'h0, 1);
      applyStimulus(0, 0, 0, 4'h0, 1);
      base = cyc + 1;
      applyStimulus(1, 0, 0, 4'h0, 8);
      applyStimulus(0, 0, 0, 4'h0, 12);
      checkQueue("bounce_up", upQ, {base + 6});

      // Down held for 60 cycles: press pulse then repeats at +16, +24 ... +56
      $display("[TB] auto-repeat");
      clearQueues();
      base = cyc + 1;
      applyStimulus(0, 1, 0, 4'h0, 60);
      applyStimulus(0, 0, 0, 4'h0, 20);
      checkQueue("repeat_down", downQ,
                 {base + 6, base + 22, base + 30, base + 38, base + 46, base + 54, base + 62});
      checkOutput("repeat_up_count", upQ.size(), 0);

      // Load capture of 4'hA, then the switches change without a load
      $display("[TB] load capture");
      clearQueues();
      applyStimulus(0, 0, 0, 4'hA, 4);
      base = cyc + 1;
      applyStimulus(0, 0, 1, 4'hA, 6);
      applyStimulus(0, 0, 0, 4'hA, 10);
      checkQueue("load_pulse", loadQ, {base + 6});
      checkOutput("load_in_q",    in_q,     4'hA);
      checkOutput("load_in_valid", in_valid, 1);
      applyStimulus(0, 0, 0, 4'h3, 10);
      checkOutput("load_in_q_hold", in_q,     4'hA);
      checkOutput("load_valid_hold", in_valid, 1);
      checkOutput("load_updown_count", upQ.size() + downQ.size(), 0);

      // Conflict: up repeating, down joins, both released in turn, up again
      $display("[TB] conflict");
      clearQueues();
      base = cyc + 1;
      applyStimulus(1, 0, 0, 4'h3, 30);
      applyStimulus(1, 1, 0, 4'h3, 20);
      checkOutput("conflict_up_held",   up_held,   1);
      checkOutput("conflict_down_held", down_held, 1);
      applyStimulus(1, 0, 0, 4'h3, 20);
      applyStimulus(0, 0, 0, 4'h3, 15);
      base2 = cyc + 1;
      applyStimulus(1, 0, 0, 4'h3, 10);
      applyStimulus(0, 0, 0, 4'h3, 15);
      checkQueue("conflict_up", upQ, {base + 6, base + 22, base + 30, base2 + 6});
      checkOutput("conflict_down_count", downQ.size(), 0);

      // Asynchronous reset while up is repeating, released with up held
      $display("[TB] async reset");
      clearQueues();
      applyStimulus(1, 0, 0, 4'h3, 25);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_up_held",  up_held,  0);
      checkOutput("arst_in_q",     in_q,     0);
      checkOutput("arst_in_valid", in_valid, 0);
      checkOutput("arst_up_pulse", up_pulse, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clearQueues();
      base = cyc + 1;
      applyStimulus(1, 0, 0, 4'h3, 24);
      applyStimulus(0, 0, 0, 4'h3, 15);
      checkQueue("arst_up", upQ, {base + 6, base + 22});
      checkOutput("arst_valid_after", in_valid, 0);
      checkOutput("arst_load_count", loadQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
